// File: rtl/reg_file_32x32_if.sv
// -----------------------------------------------------------------------------
// reg_file_32x32_if
//   Bus bundle between the datapath and the 32x32 register file.
//
//   Signals:
//     wr_en      write strobe
//     wr_addr    destination register index (ADDR_W bits)
//     wr_data    write data (DATA_W bits)
//     rd_addr_a  read port A index
//     rd_addr_b  read port B index
//     rd_data_a  read port A data (combinational from the file)
//     rd_data_b  read port B data (combinational from the file)
//
//   Modports:
//     master  datapath side: drives write/read requests, receives read data
//     slave   register-file side
// -----------------------------------------------------------------------------
interface reg_file_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/reg_file_32x32.sv
// -----------------------------------------------------------------------------
// reg_file_32x32
//   32-entry x 32-bit general-purpose register file for the single-cycle
//   datapath. One synchronous write port, two combinational read ports.
//   Register 0 has no storage and always reads zero.
//
//   Ports:
//     clk   system clock, state updates on the rising edge
//     rst   synchronous active-high reset; loads RESET_VAL into r1..r31
//           and takes priority over any write in the same cycle
//     bus   reg_file_32x32_if.slave (wr_en/wr_addr/wr_data,
//           rd_addr_a/rd_addr_b in; rd_data_a/rd_data_b out)
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, a read port whose index matches an
//                        active (non-reset, non-zero index) write returns
//                        wr_data in the same cycle. Storage is identical
//                        in both builds.
// -----------------------------------------------------------------------------
module reg_file_32x32 #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 5,
  parameter logic [DATA_W-1:0]  RESET_VAL = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_file_32x32_if.slave        bus
);

  localparam int NREG = 1 << ADDR_W;

  // Physical storage exists only for indices 1..NREG-1.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];

  // One-hot write enables; index 0 has no enable, so a write there is dropped.
  logic [NREG-1:1]   wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NREG; i++) begin
      wr_sel[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = wr_sel[i] ? bus.wr_data : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes: start from zero so index 0 falls through as the constant.
  always_comb begin
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    for (int i = 1; i < NREG; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) begin
        bus.rd_data_a = regs_q[i];
      end
      if (bus.rd_addr_b == ADDR_W'(i)) begin
        bus.rd_data_b = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // Writeback-to-decode forwarding; suppressed while reset discards the write.
    for (int i = 1; i < NREG; i++) begin
      if (!rst && wr_sel[i] && (bus.rd_addr_a == ADDR_W'(i))) begin
        bus.rd_data_a = bus.wr_data;
      end
      if (!rst && wr_sel[i] && (bus.rd_addr_b == ADDR_W'(i))) begin
        bus.rd_data_b = bus.wr_data;
      end
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
module tb_reg_file_32x32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) bif ();

  reg_file_32x32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; reads are sampled
  // after a further settle delay, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h0101_0101;
    return (i == 0) ? 32'h0 : v;
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst           = 1'b1;
    bif.wr_en     = 1'b0;
    bif.wr_addr   = '0;
    bif.wr_data   = '0;
    bif.rd_addr_a = '0;
    bif.rd_addr_b = '0;

    // Reset for one cycle, then every index reads zero on both ports.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bif.rd_addr_a = 5'(i);
      bif.rd_addr_b = 5'(31 - i);
      #1;
      check($sformatf("reset_a[%0d]", i), bif.rd_data_a, 32'h0);
      check($sformatf("reset_b[%0d]", 31 - i), bif.rd_data_b, 32'h0);
    end

    // Write then read on both ports.
    bif.wr_en = 1'b1; bif.wr_addr = 5'd5; bif.wr_data = 32'hDEAD_BEEF;
    tick();
    bif.wr_en = 1'b0;
    bif.rd_addr_a = 5'd5; bif.rd_addr_b = 5'd5;
    #1;
    check("wr_rd_a_r5", bif.rd_data_a, 32'hDEAD_BEEF);
    check("wr_rd_b_r5", bif.rd_data_b, 32'hDEAD_BEEF);

    // Hardwired zero: write to r0 is ignored, r5 untouched.
    bif.wr_en = 1'b1; bif.wr_addr = 5'd0; bif.wr_data = 32'hFFFF_FFFF;
    bif.rd_addr_a = 5'd0; bif.rd_addr_b = 5'd5;
    #1;
    check("r0_during_wr", bif.rd_data_a, 32'h0);
    tick();
    bif.wr_en = 1'b0;
    #1;
    check("r0_after_wr", bif.rd_data_a, 32'h0);
    check("r5_after_r0_wr", bif.rd_data_b, 32'hDEAD_BEEF);
    bif.rd_addr_a = 5'd1;
    #1;
    check("r1_after_r0_wr", bif.rd_data_a, 32'h0);

    // Read-during-write conflict on r7.
    bif.wr_en = 1'b1; bif.wr_addr = 5'd7; bif.wr_data = 32'h1111_1111;
    tick();
    bif.wr_addr = 5'd7; bif.wr_data = 32'h2222_2222;
    bif.rd_addr_a = 5'd7; bif.rd_addr_b = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("conflict_before_edge", bif.rd_data_a, 32'h2222_2222);
`else
    check("conflict_before_edge", bif.rd_data_a, 32'h1111_1111);
`endif
    check("conflict_other_port", bif.rd_data_b, 32'hDEAD_BEEF);
    tick();
    bif.wr_en = 1'b0;
    #1;
    check("conflict_after_edge", bif.rd_data_a, 32'h2222_2222);

    // wr_en=0 leaves storage unchanged even with data/addr presented.
    bif.wr_addr = 5'd7; bif.wr_data = 32'h3333_3333;
    tick();
    #1;
    check("wr_en_low_r7", bif.rd_data_a, 32'h2222_2222);

    // Reset dominates a same-cycle write; no forwarding during reset.
    rst = 1'b1;
    bif.wr_en = 1'b1; bif.wr_addr = 5'd9; bif.wr_data = 32'hABCD_0123;
    bif.rd_addr_a = 5'd9; bif.rd_addr_b = 5'd7;
    #1;
    check("rst_wr_r9_before", bif.rd_data_a, 32'h0);
    tick();
    rst = 1'b0;
    bif.wr_en = 1'b0;
    #1;
    check("rst_wr_r9_after", bif.rd_data_a, 32'h0);
    check("rst_clears_r7", bif.rd_data_b, 32'h0);
    bif.rd_addr_b = 5'd5;
    #1;
    check("rst_clears_r5", bif.rd_data_b, 32'h0);

    // Full sweep: r1..r31 written in consecutive cycles.
    bif.wr_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bif.wr_addr = 5'(i);
      bif.wr_data = sweep_val(i);
      tick();
    end
    bif.wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bif.rd_addr_a = 5'(i);
      bif.rd_addr_b = 5'(31 - i);
      #1;
      check($sformatf("sweep_a[%0d]", i), bif.rd_data_a, sweep_val(i));
      check($sformatf("sweep_b[%0d]", 31 - i), bif.rd_data_b, sweep_val(31 - i));
    end

    // Same index on both ports returns the same value.
    bif.rd_addr_a = 5'd17; bif.rd_addr_b = 5'd17;
    #1;
    check("same_idx_a", bif.rd_data_a, 32'h1111_1111);
    check("same_idx_b", bif.rd_data_b, 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
